// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// state codes, opcodes, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_e;

    // ALU operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows directly from the opcode
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE: imm = IMM_S;
            OP_BEQ:   imm = IMM_B;
            OP_JAL:   imm = IMM_J;
            default:  imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Translates the FSM's ALU operation class plus instruction fields into
// the 3-bit ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_e      i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_op5,
    input  logic        i_funct7b5,
    output logic [2:0]  o_alu_control
);

    // Class select first, then funct3 decode for register/immediate ops
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        // bit 30 means sub only for R-type; addi ignores it
                        if (i_op5 && i_funct7b5) begin
                            o_alu_control = ALU_SUB;
                        end else begin
                            o_alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RISC-V core (lw, sw, R/I-type,
// jal, beq) with memory-ready stalls and a sticky halt on illegal opcodes.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit P_HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_adr_src,
    output logic        o_ir_write,
    output logic        o_mem_write,
    output logic        o_reg_write,
    output logic [1:0]  o_result_src,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_imm_src,
    output logic [2:0]  o_alu_control,
    output logic        o_halt,
    output logic [3:0]  o_state
);

    state_e state_q;
    state_e state_d;
    aluop_e alu_op_s;
    logic   pc_write_s;
    logic   ir_write_s;
    logic   mem_write_s;
    logic   reg_write_s;

    // State register; reset lands in FETCH so the first edge fetches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection, holding memory states until ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (i_mem_ready) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BEQ:            state_d = BEQ;
                    default: begin
                        if (P_HALT_ON_ILLEGAL) begin
                            state_d = HALT;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                if (i_op == OP_LOAD) begin
                    state_d = MEMREAD;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            MEMREAD: begin
                if (i_mem_ready) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMWB:    state_d = FETCH;
            MEMWRITE: begin
                if (i_mem_ready) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode from the current state; selects not used are left 0
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        o_adr_src    = ADR_PC;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        alu_op_s     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                o_adr_src    = ADR_PC;
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURES;
                // no IR/PC update until memory delivers the instruction
                ir_write_s   = i_mem_ready;
                pc_write_s   = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                o_adr_src    = ADR_RESULT;
                o_result_src = RES_ALUOUT;
            end
            MEMWB: begin
                o_result_src = RES_DATA;
                reg_write_s  = 1'b1;
            end
            MEMWRITE: begin
                o_adr_src    = ADR_RESULT;
                o_result_src = RES_ALUOUT;
                mem_write_s  = 1'b1;
            end
            EXECUTER: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_RD2;
                alu_op_s    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_result_src = RES_ALUOUT;
                reg_write_s  = 1'b1;
            end
            JAL: begin
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALUOUT;
                pc_write_s   = 1'b1;
            end
            BEQ: begin
                o_alu_src_a  = SRCA_RD1;
                o_alu_src_b  = SRCB_RD2;
                o_result_src = RES_ALUOUT;
                alu_op_s     = ALUOP_SUB;
                pc_write_s   = i_zero;
            end
            HALT: begin
                pc_write_s = 1'b0;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Enables are suppressed for as long as reset is held
    always_comb begin
        o_pc_write  = pc_write_s  & i_rst_n;
        o_ir_write  = ir_write_s  & i_rst_n;
        o_mem_write = mem_write_s & i_rst_n;
        o_reg_write = reg_write_s & i_rst_n;
    end

    assign o_halt    = (state_q == HALT);
    assign o_state   = state_q;
    assign o_imm_src = imm_src_of(i_op);

    alu_decoder u_alu_decoder (
        .i_alu_op      (alu_op_s),
        .i_funct3      (i_funct3),
        .i_op5         (i_op[5]),
        .i_funct7b5    (i_funct7b5),
        .o_alu_control (o_alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a vector table of
// instructions expanded into per-cycle expectations on a scoreboard queue,
// plus hand-built sequences for stalls, reset and illegal opcodes.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
    logic       i_mem_ready;

    logic       pc_write, adr_src, ir_write, mem_write, reg_write, halt;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic       pc_write0, adr_src0, ir_write0, mem_write0, reg_write0, halt0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, imm_src0;
    logic [2:0] alu_control0;
    logic [3:0] state0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    multicycle_controller #(.P_HALT_ON_ILLEGAL(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(pc_write), .o_adr_src(adr_src), .o_ir_write(ir_write),
        .o_mem_write(mem_write), .o_reg_write(reg_write),
        .o_result_src(result_src), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_imm_src(imm_src),
        .o_alu_control(alu_control), .o_halt(halt), .o_state(state)
    );

    multicycle_controller #(.P_HALT_ON_ILLEGAL(1'b0)) u_dut_skip (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(pc_write0), .o_adr_src(adr_src0), .o_ir_write(ir_write0),
        .o_mem_write(mem_write0), .o_reg_write(reg_write0),
        .o_result_src(result_src0), .o_alu_src_a(alu_src_a0),
        .o_alu_src_b(alu_src_b0), .o_imm_src(imm_src0),
        .o_alu_control(alu_control0), .o_halt(halt0), .o_state(state0)
    );

    // {halt, state, pcw, adr, irw, memw, regw, result, srca, srcb, imm, alu}
    logic [20:0] dut_vec;
    assign dut_vec = {halt, state, pc_write, adr_src, ir_write, mem_write,
                      reg_write, result_src, alu_src_a, alu_src_b, imm_src,
                      alu_control};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] funct3;
        logic       f7b5;
        logic       zero;
        logic [2:0] alu_fn;
        logic [1:0] imm;
    } vec_t;

    typedef struct {
        string       name;
        logic        rdy;
        logic [20:0] exp;
    } sb_t;

    sb_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs for one cycle in a given state, from the state table
    function automatic logic [20:0] model(input logic [3:0] st, input logic rdy,
                                          input logic zero, input logic [2:0] alu_fn,
                                          input logic [1:0] imm);
        logic h, pcw, adr, irw, memw, regw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        h = 1'b0; pcw = 1'b0; adr = 1'b0; irw = 1'b0; memw = 1'b0; regw = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  begin sa = 2'b00; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin adr = 1'b1; end
            4'd4:  begin rs = 2'b01; regw = 1'b1; end
            4'd5:  begin adr = 1'b1; memw = 1'b1; end
            4'd6:  begin sa = 2'b10; sb = 2'b00; alu = alu_fn; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; alu = alu_fn; end
            4'd8:  begin regw = 1'b1; end
            4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            4'd10: begin sa = 2'b10; sb = 2'b00; alu = 3'b001; pcw = zero; end
            4'd11: begin h = 1'b1; end
            default: begin h = 1'b0; end
        endcase
        return {h, st, pcw, adr, irw, memw, regw, rs, sa, sb, imm, alu};
    endfunction

    task automatic push(input string name, input logic [3:0] st, input logic rdy,
                        input logic zero, input logic [2:0] alu_fn, input logic [1:0] imm);
        sb_t r;
        r.name = name;
        r.rdy  = rdy;
        r.exp  = model(st, rdy, zero, alu_fn, imm);
        sbq.push_back(r);
    endtask

    // Expand one instruction into its expected state walk (ready held high)
    task automatic push_instr(input vec_t v);
        logic [3:0] path[$];
        path = {4'd0, 4'd1};
        case (v.op)
            7'b0000011: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
            7'b0100011: begin path.push_back(4'd2); path.push_back(4'd5); end
            7'b0110011: begin path.push_back(4'd6); path.push_back(4'd8); end
            7'b0010011: begin path.push_back(4'd7); path.push_back(4'd8); end
            7'b1101111: begin path.push_back(4'd9); path.push_back(4'd8); end
            7'b1100011: begin path.push_back(4'd10); end
            default:    begin path.push_back(4'd0); end
        endcase
        i_op = v.op; i_funct3 = v.funct3; i_funct7b5 = v.f7b5; i_zero = v.zero;
        foreach (path[k]) push($sformatf("%s_c%0d", v.name, k), path[k], 1'b1, v.zero, v.alu_fn, v.imm);
    endtask

    // Apply each queued cycle and compare outputs mid-cycle
    task automatic drain();
        sb_t r;
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            i_mem_ready = r.rdy;
            @(negedge i_clk);
            chk(r.name, {11'd0, dut_vec}, {11'd0, r.exp});
            @(posedge i_clk);
            #1;
        end
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00};
        vecs[1]  = '{"sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01};
        vecs[2]  = '{"add",     7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00};
        vecs[3]  = '{"sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00};
        vecs[4]  = '{"addi_b30",7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00};
        vecs[5]  = '{"and",     7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00};
        vecs[6]  = '{"or",      7'b0110011, 3'b110, 1'b1, 1'b0, 3'b011, 2'b00};
        vecs[7]  = '{"slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00};
        vecs[8]  = '{"sll_def", 7'b0110011, 3'b001, 1'b0, 1'b0, 3'b000, 2'b00};
        vecs[9]  = '{"jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b11};
        vecs[10] = '{"beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, 2'b10};
        vecs[11] = '{"beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b10};

        // reset held: FETCH, no enables, not halted
        i_rst_n = 1'b0; i_op = 7'd0; i_funct3 = 3'd0; i_funct7b5 = 1'b0;
        i_zero = 1'b0; i_mem_ready = 1'b1;
        #3;
        chk("reset_hold", {11'd0, dut_vec}, {11'd0, 1'b0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000});
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // table-driven instruction walk, each starting from FETCH
        for (int i = 0; i < 12; i++) begin
            push_instr(vecs[i]);
            drain();
        end

        // sw with memory stall, then instruction fetch stall
        i_op = 7'b0100011; i_funct3 = 3'b010; i_funct7b5 = 1'b0; i_zero = 1'b0;
        push("stall_f",    4'd0, 1'b1, 1'b0, 3'b000, 2'b01);
        push("stall_d",    4'd1, 1'b1, 1'b0, 3'b000, 2'b01);
        push("stall_ma",   4'd2, 1'b1, 1'b0, 3'b000, 2'b01);
        push("stall_mw0",  4'd5, 1'b0, 1'b0, 3'b000, 2'b01);
        push("stall_mw1",  4'd5, 1'b0, 1'b0, 3'b000, 2'b01);
        push("stall_mw2",  4'd5, 1'b1, 1'b0, 3'b000, 2'b01);
        for (int k = 0; k < 3; k++) push($sformatf("fetch_wait%0d", k), 4'd0, 1'b0, 1'b0, 3'b000, 2'b01);
        push("fetch_go",   4'd0, 1'b1, 1'b0, 3'b000, 2'b01);
        push("fetch_dec",  4'd1, 1'b1, 1'b0, 3'b000, 2'b01);
        push("fetch_ma",   4'd2, 1'b1, 1'b0, 3'b000, 2'b01);
        push("fetch_mw",   4'd5, 1'b1, 1'b0, 3'b000, 2'b01);
        drain();

        // reset asserted while a store is stalled in MEMWRITE
        push("rst_f",   4'd0, 1'b1, 1'b0, 3'b000, 2'b01);
        push("rst_d",   4'd1, 1'b1, 1'b0, 3'b000, 2'b01);
        push("rst_ma",  4'd2, 1'b1, 1'b0, 3'b000, 2'b01);
        push("rst_mw0", 4'd5, 1'b0, 1'b0, 3'b000, 2'b01);
        push("rst_mw1", 4'd5, 1'b0, 1'b0, 3'b000, 2'b01);
        drain();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_mw", {11'd0, dut_vec}, {11'd0, 1'b0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000});
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        push("post_rst_f", 4'd0, 1'b1, 1'b0, 3'b000, 2'b01);
        push("post_rst_d", 4'd1, 1'b1, 1'b0, 3'b000, 2'b01);
        push("post_rst_ma",4'd2, 1'b1, 1'b0, 3'b000, 2'b01);
        push("post_rst_mw",4'd5, 1'b1, 1'b0, 3'b000, 2'b01);
        drain();

        // illegal opcode: halting core sticks in HALT, skipping core refetches
        i_op = 7'b0000000; i_funct3 = 3'b000;
        push("ill_f", 4'd0, 1'b1, 1'b0, 3'b000, 2'b00);
        push("ill_d", 4'd1, 1'b1, 1'b0, 3'b000, 2'b00);
        drain();
        @(negedge i_clk);
        chk("ill_halt0", {11'd0, dut_vec}, {11'd0, model(4'd11, 1'b1, 1'b0, 3'b000, 2'b00)});
        chk("ill_skip_state", {27'd0, halt0, state0}, {27'd0, 1'b0, 4'd0});
        @(posedge i_clk); #1;
        chk("ill_skip_next", {28'd0, state0}, {28'd0, 4'd1});
        for (int k = 1; k < 10; k++) push($sformatf("ill_halt%0d", k), 4'd11, 1'b1, 1'b0, 3'b000, 2'b00);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
